rx_frontend: RTL and testbench

//  UART receive deserializer; counterpart of the transmit frontend on the same serial link.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/synchronizer.sv | 23 ++
 rtl/rx_frontend.sv | 170 +++++++++++++++++
 tb/tb_rx_frontend.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART frame states and configuration encodings shared by rx/tx frontends
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  localparam logic DS_7   = 1'b0;
  localparam logic DS_8   = 1'b1;
  localparam logic STOP_1 = 1'b0;
  localparam logic STOP_2 = 1'b1;

  // One-hot bit counter seed for the data field; bit 0 marks the last data bit.
  function automatic logic [7:0] data_bit_seed(input logic ds);
    return (ds == DS_8) ? 8'h80 : 8'h40;
  endfunction

endpackage

// File: rtl/synchronizer.sv
// rtl/synchronizer.sv - multi-flop synchronizer for an asynchronous line, resets to idle-high
module synchronizer #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] ff_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = ff_q[STAGES-1];

endmodule

// File: rtl/rx_frontend.sv
// rtl/rx_frontend.sv - UART receive deserializer with mid-bit sampling, parity and stop checks
module rx_frontend
  import uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] cr_clk_div_i,
  input  logic        cr_ds_i,
  input  logic [1:0]  cr_p_i,
  input  logic        cr_s_i,
  input  logic        uart_rx_i,
  output logic [7:0]  dr_o,
  output logic        valid_o,
  output logic        parity_error_o,
  output logic        frame_error_o
);

  logic rx_s;

  synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (uart_rx_i),
    .q_o   (rx_s)
  );

  state_t      state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [15:0] div_q, div_d;
  logic [7:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        ds_q, ds_d;
  logic [1:0]  p_q, p_d;
  logic        s_q, s_d;
  logic        par_q, par_d;
  logic        perr_q, perr_d;
  logic        ferr_q, ferr_d;
  logic        seen_high_q, seen_high_d;
  logic [7:0]  dr_q, dr_d;
  logic        valid_q, valid_d;
  logic        pe_q, pe_d;
  logic        fe_q, fe_d;
  logic        sample;

  assign sample = (baud_q == 16'd0);

  always_comb begin
    state_d     = state_q;
    baud_d      = baud_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shift_d     = shift_q;
    ds_d        = ds_q;
    p_d         = p_q;
    s_d         = s_q;
    par_d       = par_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    seen_high_d = seen_high_q;
    dr_d        = dr_q;
    valid_d     = 1'b0;
    pe_d        = pe_q;
    fe_d        = fe_q;

    if (state_q == IDLE) begin
      if (rx_s) seen_high_d = 1'b1;
      // A falling edge only counts after the line was seen high, so a held break is ignored.
      if (!rx_s && seen_high_q) begin
        state_d = START;
        ds_d    = cr_ds_i;
        p_d     = cr_p_i;
        s_d     = cr_s_i;
        div_d   = cr_clk_div_i;
        baud_d  = (cr_clk_div_i >> 1) - 16'd1;
        par_d   = 1'b0;
        perr_d  = 1'b0;
        ferr_d  = 1'b0;
      end
    end else if (!sample) begin
      baud_d = baud_q - 16'd1;
    end else begin
      baud_d = div_q - 16'd1;
      case (state_q)
        START: begin
          if (!rx_s) begin
            state_d = DATA;
            bit_d   = data_bit_seed(ds_q);
            shift_d = 8'h00;
          end else begin
            state_d     = IDLE;
            seen_high_d = 1'b1;
          end
        end
        DATA: begin
          shift_d = {rx_s, shift_q[7:1]};
          par_d   = par_q ^ rx_s;
          bit_d   = bit_q >> 1;
          if (bit_q[0]) begin
            if (ds_q == DS_7) shift_d = {1'b0, rx_s, shift_q[7:2]};
            state_d = (p_q != PAR_NONE) ? PARITY : STOP;
            bit_d   = (s_q == STOP_2) ? 8'h02 : 8'h01;
          end
        end
        PARITY: begin
          perr_d  = rx_s ^ p_q[0] ^ par_q;
          state_d = STOP;
        end
        STOP: begin
          ferr_d = ferr_q | ~rx_s;
          bit_d  = bit_q >> 1;
          if (bit_q[0]) begin
            dr_d        = shift_q;
            pe_d        = perr_q;
            fe_d        = ferr_q | ~rx_s;
            valid_d     = 1'b1;
            state_d     = IDLE;
            seen_high_d = rx_s;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      baud_q      <= 16'd0;
      div_q       <= 16'd0;
      bit_q       <= 8'h00;
      shift_q     <= 8'h00;
      ds_q        <= DS_8;
      p_q         <= PAR_NONE;
      s_q         <= STOP_1;
      par_q       <= 1'b0;
      perr_q      <= 1'b0;
      ferr_q      <= 1'b0;
      seen_high_q <= 1'b0;
      dr_q        <= 8'h00;
      valid_q     <= 1'b0;
      pe_q        <= 1'b0;
      fe_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      baud_q      <= baud_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shift_q     <= shift_d;
      ds_q        <= ds_d;
      p_q         <= p_d;
      s_q         <= s_d;
      par_q       <= par_d;
      perr_q      <= perr_d;
      ferr_q      <= ferr_d;
      seen_high_q <= seen_high_d;
      dr_q        <= dr_d;
      valid_q     <= valid_d;
      pe_q        <= pe_d;
      fe_q        <= fe_d;
    end
  end

  assign dr_o           = dr_q;
  assign valid_o        = valid_q;
  assign parity_error_o = pe_q;
  assign frame_error_o  = fe_q;

endmodule

// File: tb/tb_rx_frontend.sv
// tb/tb_rx_frontend.sv - scoreboard bench for rx_frontend with directed serial frames
module tb_rx_frontend;
  import uart_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [15:0] cr_clk_div_i = 16'd4;
  logic        cr_ds_i = 1'b1;
  logic [1:0]  cr_p_i = 2'b00;
  logic        cr_s_i = 1'b0;
  logic        uart_rx_i = 1'b1;
  logic [7:0]  dr_o;
  logic        valid_o;
  logic        parity_error_o;
  logic        frame_error_o;

  rx_frontend #(.SYNC_STAGES(2)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .cr_clk_div_i   (cr_clk_div_i),
    .cr_ds_i        (cr_ds_i),
    .cr_p_i         (cr_p_i),
    .cr_s_i         (cr_s_i),
    .uart_rx_i      (uart_rx_i),
    .dr_o           (dr_o),
    .valid_o        (valid_o),
    .parity_error_o (parity_error_o),
    .frame_error_o  (frame_error_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_valid = 0;
  int   v0;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  always @(negedge clk_i) begin
    if (valid_o) begin
      n_valid++;
      check("valid_single_cycle", {31'd0, prev_valid}, 32'd0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_valid: got dr=%0h expected no frame", dr_o);
      end else begin
        e = exp_q.pop_front();
        check("dr_o", {24'd0, dr_o}, {24'd0, e.d});
        check("parity_error_o", {31'd0, parity_error_o}, {31'd0, e.pe});
        check("frame_error_o", {31'd0, frame_error_o}, {31'd0, e.fe});
      end
    end
    prev_valid = valid_o;
  end

  task automatic push(input logic [7:0] d, input logic pe, input logic fe);
    exp_t x;
    x.d  = d;
    x.pe = pe;
    x.fe = fe;
    exp_q.push_back(x);
  endtask

  task automatic drive_bit(input int div, input logic v);
    uart_rx_i = v;
    repeat (div) @(negedge clk_i);
  endtask

  task automatic send_frame(input int div, input logic [7:0] data, input int nbits,
                            input bit has_par, input logic par_bit,
                            input int nstop, input logic stop_val);
    drive_bit(div, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(div, data[i]);
    if (has_par) drive_bit(div, par_bit);
    for (int i = 0; i < nstop; i++) drive_bit(div, stop_val);
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < limit) begin
      @(negedge clk_i);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d frames pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk_i);
    check("reset_dr", {24'd0, dr_o}, 32'd0);
    check("reset_valid", {31'd0, valid_o}, 32'd0);
    check("reset_pe", {31'd0, parity_error_o}, 32'd0);
    check("reset_fe", {31'd0, frame_error_o}, 32'd0);
    rst_i = 1'b0;
    repeat (5) @(negedge clk_i);

    // 8N1 at div=4
    push(8'hA5, 1'b0, 1'b0);
    send_frame(4, 8'hA5, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (16) @(negedge clk_i);
    drain(200);

    // 7 bits, odd parity, two stop bits, good then bad parity
    cr_clk_div_i = 16'd16; cr_ds_i = 1'b0; cr_p_i = 2'b01; cr_s_i = 1'b1;
    repeat (4) @(negedge clk_i);
    push(8'h41, 1'b0, 1'b0);
    send_frame(16, 8'h41, 7, 1'b1, 1'b1, 2, 1'b1);
    repeat (32) @(negedge clk_i);
    push(8'h41, 1'b1, 1'b0);
    send_frame(16, 8'h41, 7, 1'b1, 1'b0, 2, 1'b1);
    repeat (32) @(negedge clk_i);
    drain(400);

    // stop bit low followed by a held break
    cr_clk_div_i = 16'd8; cr_ds_i = 1'b1; cr_p_i = 2'b00; cr_s_i = 1'b0;
    repeat (4) @(negedge clk_i);
    v0 = n_valid;
    push(8'h3C, 1'b0, 1'b1);
    send_frame(8, 8'h3C, 8, 1'b0, 1'b0, 1, 1'b0);
    repeat (160) @(negedge clk_i);
    drain(50);
    check("break_single_frame", n_valid - v0, 32'd1);
    uart_rx_i = 1'b1;
    repeat (32) @(negedge clk_i);
    check("idle_after_break", {29'd0, dut.state_q}, {29'd0, IDLE});

    // short low glitch in idle
    cr_clk_div_i = 16'd16;
    repeat (4) @(negedge clk_i);
    v0 = n_valid;
    drive_bit(3, 1'b0);
    drive_bit(40, 1'b1);
    check("glitch_no_valid", n_valid - v0, 32'd0);
    check("idle_after_glitch", {29'd0, dut.state_q}, {29'd0, IDLE});

    // back-to-back frames at div=4
    cr_clk_div_i = 16'd4;
    repeat (4) @(negedge clk_i);
    v0 = n_valid;
    push(8'h00, 1'b0, 1'b0);
    push(8'hFF, 1'b0, 1'b0);
    push(8'h55, 1'b0, 1'b0);
    send_frame(4, 8'h00, 8, 1'b0, 1'b0, 1, 1'b1);
    send_frame(4, 8'hFF, 8, 1'b0, 1'b0, 1, 1'b1);
    send_frame(4, 8'h55, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (16) @(negedge clk_i);
    drain(200);
    check("back_to_back_count", n_valid - v0, 32'd3);

    // reset in the middle of the data field
    drive_bit(4, 1'b0);
    drive_bit(4, 1'b1);
    drive_bit(4, 1'b0);
    drive_bit(4, 1'b0);
    check("in_data_before_reset", {29'd0, dut.state_q}, {29'd0, DATA});
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midreset_dr", {24'd0, dr_o}, 32'd0);
    check("midreset_valid", {31'd0, valid_o}, 32'd0);
    check("midreset_pe", {31'd0, parity_error_o}, 32'd0);
    check("midreset_fe", {31'd0, frame_error_o}, 32'd0);
    check("midreset_state", {29'd0, dut.state_q}, {29'd0, IDLE});
    uart_rx_i = 1'b1;
    rst_i = 1'b0;
    repeat (10) @(negedge clk_i);
    push(8'h81, 1'b0, 1'b0);
    send_frame(4, 8'h81, 8, 1'b0, 1'b0, 1, 1'b1);
    repeat (16) @(negedge clk_i);
    drain(200);

    check("total_frames", n_valid, 32'd8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
